// File: rtl/reqack_pkg.sv
// Shared definitions for two-phase request/acknowledge blocks.
//   clog2_min1  : pointer width for a storage depth, never less than 1 bit
//   SYNC_STAGES : flop count used on asynchronous req/ack crossings
package reqack_pkg;

    localparam int SYNC_STAGES = 2;

    // Pointer width helper. It returns at least 1 so that a depth of 1 or 2
    // still gives a legal, non-zero-width pointer.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reqack_cdc_sync.sv
// N-flop synchronizer for a single-bit two-phase level (req or ack).
//   clk  : destination clock
//   rst  : asynchronous active-high reset, all flops clear to 0
//   i_d  : asynchronous input level
//   o_q  : synchronized level, STAGES clock edges after i_d
module reqack_cdc_sync
    import reqack_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/reqack_tph_sink_fifo.sv
// Terminal sink of a two-phase req/ack pipeline. Each req phase change is
// taken into a small FIFO. The FIFO contents are offered to synchronous
// logic on a valid/ready stream.
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset (control only, not storage)
//   req      : two-phase request; each toggle is one transfer
//   ack      : two-phase acknowledge, registered, toggles once per push
//   i_dat    : bundled data, stable while req != ack
//   o_vld    : FIFO non-empty
//   o_rdy    : consumer takes the head entry when o_vld & o_rdy
//   o_dat    : head-of-FIFO data (combinational read)
//   o_level  : number of stored entries
module reqack_tph_sink_fifo
    import reqack_pkg::*;
#(
    parameter int DWIDTH          = 1,
    parameter int DEPTH           = 4,
    parameter bit INCLUDE_CDC_PRV = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req,
    output logic                       ack,
    input  logic [DWIDTH-1:0]          i_dat,
    output logic                       o_vld,
    input  logic                       o_rdy,
    output logic [DWIDTH-1:0]          o_dat,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int AW = clog2_min1(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("reqack_tph_sink_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic w_req;

    if (INCLUDE_CDC_PRV) begin : g_cdc
        reqack_cdc_sync #(
            .STAGES (SYNC_STAGES)
        ) u_req_sync (
            .clk (clk),
            .rst (rst),
            .i_d (req),
            .o_q (w_req)
        );
    end else begin : g_no_cdc
        assign w_req = req;
    end

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              r_ack;

    logic w_full;
    logic w_pending;
    logic w_push;
    logic w_pop;

    // A full FIFO blocks the push even when a pop happens on the same edge.
    // The held request is then taken on the following edge. This keeps the
    // push decision independent of o_rdy.
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_pending = w_req ^ r_ack;
    assign w_push    = w_pending & ~w_full;
    assign w_pop     = o_vld & o_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack   <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
                r_ack  <= ~r_ack;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_dat;
        end
    end

    assign ack     = r_ack;
    assign o_vld   = (r_count != '0);
    assign o_dat   = r_mem[r_rptr];
    assign o_level = r_count;

`ifndef SYNTHESIS
    a_dat_known: assert property (@(posedge clk) disable iff (rst)
        o_vld |-> !$isunknown(o_dat));
    a_count_max: assert property (@(posedge clk) disable iff (rst)
        r_count <= CW'(DEPTH));
    a_no_empty_pop: assert property (@(posedge clk) disable iff (rst)
        w_pop |-> (r_count != '0));
`endif

endmodule

// File: tb/tb_reqack_tph_sink_fifo.sv
module tb_reqack_tph_sink_fifo;

    logic       clk = 1'b0;
    logic       rst;
    // DUT without CDC
    logic       req, ack, rdy, vld;
    logic [7:0] dat, odat;
    logic [2:0] level;
    // DUT with CDC
    logic       req_c, ack_c, rdy_c, vld_c;
    logic [7:0] dat_c, odat_c;
    logic [2:0] level_c;

    int n_chk  = 0;
    int n_fail = 0;
    int n_tog  = 0;

    logic [7:0] sbq   [$];
    logic [7:0] sbq_c [$];
    logic [7:0] e_m, e_c;

    always #5 clk = ~clk;

    reqack_tph_sink_fifo #(.DWIDTH(8), .DEPTH(4), .INCLUDE_CDC_PRV(1'b0)) u_dut (
        .clk(clk), .rst(rst), .req(req), .ack(ack), .i_dat(dat),
        .o_vld(vld), .o_rdy(rdy), .o_dat(odat), .o_level(level)
    );

    reqack_tph_sink_fifo #(.DWIDTH(8), .DEPTH(4), .INCLUDE_CDC_PRV(1'b1)) u_cdc (
        .clk(clk), .rst(rst), .req(req_c), .ack(ack_c), .i_dat(dat_c),
        .o_vld(vld_c), .o_rdy(rdy_c), .o_dat(odat_c), .o_level(level_c)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Upstream model: wait for the previous transfer to be acknowledged,
    // then present data and toggle req.
    task automatic send(input logic [7:0] d);
        int n = 0;
        while (req !== ack && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: ack %0b, expected %0b", ack, req);
        end
        dat = d;
        req = ~req;
        sbq.push_back(d);
    endtask

    task automatic drain();
        int n = 0;
        rdy = 1'b1;
        while (level != 0 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: level %0d, expected 0", level);
        end
        rdy = 1'b0;
    endtask

    always @(ack) if (!rst) n_tog++;

    // Scoreboard monitors: a pop happens on the next rising edge.
    always @(negedge clk) begin
        if (!rst && vld && rdy) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL pop_unexpected: got %0h, expected no data", odat);
            end else begin
                e_m = sbq.pop_front();
                chk("pop_data", {24'd0, odat}, {24'd0, e_m});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && vld_c && rdy_c) begin
            if (sbq_c.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL cdc_pop_unexpected: got %0h, expected no data", odat_c);
            end else begin
                e_c = sbq_c.pop_front();
                chk("cdc_pop_data", {24'd0, odat_c}, {24'd0, e_c});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        int nxt;
        int maxlvl;

        rst = 1'b1; req = 1'b0; rdy = 1'b0; dat = 8'h00;
        req_c = 1'b0; rdy_c = 1'b0; dat_c = 8'h00;
        #2;
        chk("rst_ack", ack, 0);
        chk("rst_vld", vld, 0);
        chk("rst_level", level, 0);
        chk("rst_cdc_ack", ack_c, 0);
        chk("rst_cdc_level", level_c, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single transfer
        rdy = 1'b1;
        send(8'hA5);
        chk("single_ack_before", ack, 0);
        chk("single_vld_before", vld, 0);
        tick();
        chk("single_ack", ack, 1);
        chk("single_vld", vld, 1);
        chk("single_dat", odat, 8'hA5);
        chk("single_level", level, 1);
        tick();
        chk("single_level_after", level, 0);
        chk("single_vld_after", vld, 0);
        rdy = 1'b0;

        // Fill and stall
        t0 = n_tog;
        for (int i = 1; i <= 5; i++) send(8'(i));
        tick(); tick(); tick();
        chk("fill_level", level, 4);
        chk("fill_pending", req ^ ack, 1);
        chk("fill_toggles", n_tog - t0, 4);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        chk("stall_pop_level", level, 3);
        chk("stall_no_passthru", req ^ ack, 1);
        tick();
        chk("stall_refill_level", level, 4);
        chk("stall_refill_ack", req ^ ack, 0);
        chk("stall_toggles", n_tog - t0, 5);
        drain();
        chk("fill_sb_empty", sbq.size(), 0);

        // Wrap-around with o_rdy toggling every other cycle
        nxt = 0;
        maxlvl = 0;
        for (int c = 0; c < 300 && (nxt < 10 || level != 0); c++) begin
            if (c % 2 == 0) rdy = ~rdy;
            if (nxt < 10 && req == ack) begin
                send(8'(nxt));
                nxt++;
            end
            tick();
            if (level > maxlvl) maxlvl = level;
        end
        rdy = 1'b0;
        chk("wrap_sent", nxt, 10);
        chk("wrap_level", level, 0);
        chk("wrap_max_le4", (maxlvl <= 4), 1);
        chk("wrap_sb_empty", sbq.size(), 0);

        // Simultaneous push and pop at level 2
        send(8'h11);
        tick();
        send(8'h22);
        tick();
        chk("pp_level_pre", level, 2);
        rdy = 1'b1;
        send(8'h33);
        tick();
        rdy = 1'b0;
        chk("pp_level", level, 2);
        chk("pp_ack", req ^ ack, 0);
        chk("pp_head", odat, 8'h22);
        drain();
        chk("pp_sb_empty", sbq.size(), 0);

        // CDC: ack responds on the third edge
        rdy_c = 1'b1;
        dat_c = 8'h3C;
        req_c = 1'b1;
        sbq_c.push_back(8'h3C);
        tick();
        chk("cdc_ack_e1", ack_c, 0);
        tick();
        chk("cdc_ack_e2", ack_c, 0);
        tick();
        chk("cdc_ack_e3", ack_c, 1);
        chk("cdc_vld", vld_c, 1);
        chk("cdc_dat", odat_c, 8'h3C);
        tick();
        chk("cdc_level_after", level_c, 0);
        chk("cdc_sb_empty", sbq_c.size(), 0);

        // Reset mid-operation at level 3 with a request pending
        send(8'h71);
        tick();
        send(8'h72);
        tick();
        send(8'h73);
        tick();
        chk("rst_mid_level_pre", level, 3);
        send(8'h74);
        sbq.delete();
        #1;
        rst = 1'b1;
        req = 1'b0;
        req_c = 1'b0;
        #1;
        chk("rst_mid_ack", ack, 0);
        chk("rst_mid_vld", vld, 0);
        chk("rst_mid_level", level, 0);
        tick();
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        chk("post_rst_ack", ack, 0);
        chk("post_rst_level", level, 0);
        chk("post_rst_vld", vld, 0);
        chk("post_rst_cdc_level", level_c, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
